bp_cce_hybrid_req_merge: RTL

- Sits directly downstream of the hybrid CCE pending queue.
- Merges two LCE request BedRock Burst streams into the single request stream consumed by the CCE request pipe:
  - replayed requests drained from the pending queue (valid->yumi);
  - fresh LCE requests from the network (ready&valid).
- Arbitrates per message and locks the winning source from header until last data beat, so bursts never interleave.

---
 rtl/bp_cce_hybrid_req_merge_pkg.sv | 21 ++
 rtl/bp_cce_hybrid_req_merge.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bp_cce_hybrid_req_merge_pkg.sv
// Shared types for the hybrid CCE request merge: LCE request header layout and merge FSM states.
package bp_cce_hybrid_req_merge_pkg;

    localparam int lce_data_width_gp = 64;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [7:0]  lce_id;
    } bp_bedrock_lce_req_header_s;

    localparam int lce_req_msg_header_width_gp = $bits(bp_bedrock_lce_req_header_s);

    typedef enum logic [1:0] {
        e_ready,
        e_header,
        e_data
    } bp_cce_hybrid_req_merge_state_e;

endpackage

// File: rtl/bp_cce_hybrid_req_merge.sv
// Merges pending-queue replays and fresh LCE requests into one burst stream, locking the source per message.
// Optional starvation guard for fresh requests: define BP_CCE_HYBRID_REQ_MERGE_FAIR_EN.
module bp_cce_hybrid_req_merge
    import bp_cce_hybrid_req_merge_pkg::*;
#(
    parameter int lce_data_width_p = lce_data_width_gp
`ifdef BP_CCE_HYBRID_REQ_MERGE_FAIR_EN
  , parameter int starve_limit_p = 4
`endif
  , localparam int lce_req_msg_header_width_lp = lce_req_msg_header_width_gp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [lce_req_msg_header_width_lp-1:0] pend_header_i,
    input  logic                                   pend_header_v_i,
    output logic                                   pend_header_yumi_o,
    input  logic                                   pend_has_data_i,
    input  logic [lce_data_width_p-1:0]            pend_data_i,
    input  logic                                   pend_data_v_i,
    output logic                                   pend_data_yumi_o,
    input  logic                                   pend_last_i,

    input  logic [lce_req_msg_header_width_lp-1:0] new_header_i,
    input  logic                                   new_header_v_i,
    output logic                                   new_header_ready_and_o,
    input  logic                                   new_has_data_i,
    input  logic [lce_data_width_p-1:0]            new_data_i,
    input  logic                                   new_data_v_i,
    output logic                                   new_data_ready_and_o,
    input  logic                                   new_last_i,

    output logic [lce_req_msg_header_width_lp-1:0] lce_req_header_o,
    output logic                                   lce_req_header_v_o,
    input  logic                                   lce_req_header_ready_and_i,
    output logic                                   lce_req_has_data_o,
    output logic [lce_data_width_p-1:0]            lce_req_data_o,
    output logic                                   lce_req_data_v_o,
    input  logic                                   lce_req_data_ready_and_i,
    output logic                                   lce_req_last_o,

    output logic                                   grant_pend_o,
    output logic                                   busy_o
);

    bp_cce_hybrid_req_merge_state_e state_r, state_n;
    logic src_r, src_n;
    logic sel_pend, sel_hdr_v, hdr_phase, in_data, hdr_hs, data_hs, prefer_new;

`ifdef BP_CCE_HYBRID_REQ_MERGE_FAIR_EN
    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    logic [cnt_width_lp-1:0] starve_cnt_r;

    assign prefer_new = (starve_cnt_r == cnt_width_lp'(starve_limit_p)) & new_header_v_i;

    // Counts pending grants that overtook a waiting fresh request
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_r <= '0;
        end else if (hdr_hs & ~sel_pend) begin
            starve_cnt_r <= '0;
        end else if (pend_header_yumi_o & new_header_v_i
                     & (starve_cnt_r != cnt_width_lp'(starve_limit_p))) begin
            starve_cnt_r <= starve_cnt_r + cnt_width_lp'(1);
        end
    end
`else
    assign prefer_new = 1'b0;
`endif

    // Outside e_ready the source is locked so a burst never interleaves
    assign sel_pend  = (state_r == e_ready) ? (pend_header_v_i & ~prefer_new) : src_r;
    assign sel_hdr_v = sel_pend ? pend_header_v_i : new_header_v_i;
    assign hdr_phase = reset_n_i & (state_r != e_data);
    assign in_data   = reset_n_i & (state_r == e_data);

    assign lce_req_header_v_o     = hdr_phase & sel_hdr_v;
    assign hdr_hs                 = lce_req_header_v_o & lce_req_header_ready_and_i;
    assign pend_header_yumi_o     = hdr_hs & sel_pend;
    assign new_header_ready_and_o = hdr_phase & lce_req_header_ready_and_i & ~sel_pend;

    assign lce_req_data_v_o     = in_data & (src_r ? pend_data_v_i : new_data_v_i);
    assign data_hs              = lce_req_data_v_o & lce_req_data_ready_and_i;
    assign pend_data_yumi_o     = data_hs & src_r;
    assign new_data_ready_and_o = in_data & lce_req_data_ready_and_i & ~src_r;

    assign lce_req_header_o   = sel_pend ? pend_header_i   : new_header_i;
    assign lce_req_has_data_o = sel_pend ? pend_has_data_i : new_has_data_i;
    assign lce_req_data_o     = sel_pend ? pend_data_i     : new_data_i;
    assign lce_req_last_o     = sel_pend ? pend_last_i     : new_last_i;

    assign grant_pend_o = reset_n_i & sel_pend;
    assign busy_o       = (state_r != e_ready);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            src_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            src_r   <= src_n;
        end
    end

    // A stalled header parks in e_header so the chosen source stays stable until accepted
    always_comb begin
        state_n = state_r;
        src_n   = src_r;
        case (state_r)
            e_ready: begin
                if (lce_req_header_v_o) begin
                    src_n = sel_pend;
                    if (!hdr_hs) begin
                        state_n = e_header;
                    end else if (lce_req_has_data_o) begin
                        state_n = e_data;
                    end
                end
            end
            e_header: begin
                if (hdr_hs) begin
                    state_n = lce_req_has_data_o ? e_data : e_ready;
                end
            end
            e_data: begin
                if (data_hs & lce_req_last_o) begin
                    state_n = e_ready;
                end
            end
            default: begin
                state_n = e_ready;
            end
        endcase
    end

endmodule
